// File: rtl/motor_drive_ctrl_pkg.sv
// Shared definitions for the drum motor drive stage: command codes, FSM states and default levels.
// The command codes match the ones the washer controller FSM drives.
package motor_drive_ctrl_pkg;

  typedef enum logic [1:0] {
    MOTOR_OFF  = 2'd0,
    MOTOR_WASH = 2'd1,
    MOTOR_SPIN = 2'd2
  } motor_cmd_e;

  typedef enum logic [2:0] {
    StOff,
    StRampUp,
    StRun,
    StRampDn,
    StPause,
    StFault
  } drive_state_e;

  localparam int unsigned DefPwmBits      = 8;
  localparam int unsigned DefWashDuty     = 128;
  localparam int unsigned DefSpinDuty     = 240;
  localparam int unsigned DefRampStep     = 4;
  localparam int unsigned DefRampDiv      = 4;
  localparam int unsigned DefAgitateTime  = 16;
  localparam int unsigned DefReversePause = 4;

endpackage

// File: rtl/motor_drive_ctrl_pwm_gen.sv
// Free-running PWM counter with a registered compare output.
// pwm_o reflects (counter < duty_i) one cycle after the compare.
module motor_drive_ctrl_pwm_gen #(
  parameter int unsigned PwmBits = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [PwmBits-1:0] duty_i,
  output logic               pwm_o
);

  logic [PwmBits-1:0] cnt_q, cnt_d;
  logic               pwm_q, pwm_d;

  always_comb begin
    cnt_d = cnt_q + PwmBits'(1);
    pwm_d = (cnt_q < duty_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pwm_q <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/motor_drive_ctrl.sv
// Drum motor drive: soft-ramped PWM duty, wash agitation with braked reversals,
// fixed clockwise spin and a sticky door interlock fault.
module motor_drive_ctrl
  import motor_drive_ctrl_pkg::*;
#(
  parameter int unsigned PWM_BITS      = DefPwmBits,
  parameter int unsigned WASH_DUTY     = DefWashDuty,
  parameter int unsigned SPIN_DUTY     = DefSpinDuty,
  parameter int unsigned RAMP_STEP     = DefRampStep,
  parameter int unsigned RAMP_DIV      = DefRampDiv,
  parameter int unsigned AGITATE_TIME  = DefAgitateTime,
  parameter int unsigned REVERSE_PAUSE = DefReversePause
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          motor_cmd,
  input  logic                lock_door,
  input  logic                door_closed,
  output logic                pwm_out,
  output logic                dir_cw,
  output logic                brake,
  output logic                running,
  output logic                fault,
  output logic [PWM_BITS-1:0] duty
);

  localparam int unsigned DivW   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int unsigned AgitW  = (AGITATE_TIME > 1) ? $clog2(AGITATE_TIME) : 1;
  localparam int unsigned PauseW = (REVERSE_PAUSE > 1) ? $clog2(REVERSE_PAUSE) : 1;

  localparam logic [DivW-1:0]     DivMax   = DivW'(RAMP_DIV - 1);
  localparam logic [AgitW-1:0]    AgitMax  = AgitW'(AGITATE_TIME - 1);
  localparam logic [PauseW-1:0]   PauseMax = PauseW'(REVERSE_PAUSE - 1);
  localparam logic [PWM_BITS-1:0] WashLvl  = PWM_BITS'(WASH_DUTY);
  localparam logic [PWM_BITS-1:0] SpinLvl  = PWM_BITS'(SPIN_DUTY);
  localparam logic [PWM_BITS:0]   StepLvl  = (PWM_BITS + 1)'(RAMP_STEP);

  // One ramp step toward tgt; saturates at tgt so it cannot overshoot or wrap.
  function automatic logic [PWM_BITS-1:0] ramp_toward(input logic [PWM_BITS-1:0] cur,
                                                      input logic [PWM_BITS-1:0] tgt);
    logic [PWM_BITS:0]   gap;
    logic [PWM_BITS-1:0] res;
    gap = '0;
    res = tgt;
    if (cur < tgt) begin
      gap = {1'b0, tgt} - {1'b0, cur};
      if (gap > StepLvl) res = cur + StepLvl[PWM_BITS-1:0];
    end else if (cur > tgt) begin
      gap = {1'b0, cur} - {1'b0, tgt};
      if (gap > StepLvl) res = cur - StepLvl[PWM_BITS-1:0];
    end
    return res;
  endfunction

  drive_state_e        state_q, state_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                dir_cw_q, dir_cw_d;
  logic                rev_q, rev_d;
  logic                brake_q, brake_d;
  logic                fault_q, fault_d;
  logic                running_q, running_d;
  logic [DivW-1:0]     div_cnt_q, div_cnt_d;
  logic [AgitW-1:0]    agit_cnt_q, agit_cnt_d;
  logic [PauseW-1:0]   pause_cnt_q, pause_cnt_d;

  logic                cmd_wash, cmd_spin, cmd_on;
  logic                ilock_ok, dir_chg, tick;
  logic [PWM_BITS-1:0] target, eff_target, ramp_duty;

  always_comb begin
    cmd_wash   = (motor_cmd == MOTOR_WASH);
    cmd_spin   = (motor_cmd == MOTOR_SPIN);
    cmd_on     = cmd_wash || cmd_spin;
    ilock_ok   = door_closed && lock_door;
    target     = cmd_wash ? WashLvl : (cmd_spin ? SpinLvl : '0);
    // Reversal or a CCW->CW change must pass through zero duty and a braked pause.
    dir_chg    = cmd_spin && !dir_cw_q;
    eff_target = (rev_q || dir_chg) ? '0 : target;
    tick       = (div_cnt_q == DivMax);
    div_cnt_d  = tick ? '0 : div_cnt_q + DivW'(1);
    ramp_duty  = tick ? ramp_toward(duty_q, eff_target) : duty_q;
  end

  always_comb begin
    state_d     = state_q;
    duty_d      = duty_q;
    dir_cw_d    = dir_cw_q;
    rev_d       = rev_q;
    agit_cnt_d  = '0;
    pause_cnt_d = '0;

    if (!ilock_ok && ((duty_q != '0) || cmd_on)) begin
      state_d = StFault;
      duty_d  = '0;
      rev_d   = 1'b0;
    end else begin
      unique case (state_q)
        StOff: begin
          duty_d = '0;
          if (cmd_on) state_d = StRampUp;
        end
        StRampUp, StRampDn: begin
          duty_d = ramp_duty;
          if (ramp_duty == eff_target) begin
            if (eff_target != '0)       state_d = StRun;
            else if (rev_q || dir_chg) state_d = StPause;
            else                       state_d = StOff;
          end else begin
            state_d = (eff_target < ramp_duty) ? StRampDn : StRampUp;
          end
        end
        StRun: begin
          if (eff_target != duty_q) begin
            state_d = (eff_target < duty_q) ? StRampDn : StRampUp;
          end else if (cmd_wash) begin
            if (agit_cnt_q == AgitMax) begin
              state_d = StRampDn;
              rev_d   = 1'b1;
            end else begin
              agit_cnt_d = agit_cnt_q + AgitW'(1);
            end
          end
        end
        StPause: begin
          duty_d = '0;
          if (pause_cnt_q == PauseMax) begin
            if (cmd_spin)   dir_cw_d = 1'b1;
            else if (rev_q) dir_cw_d = !dir_cw_q;
            rev_d   = 1'b0;
            state_d = cmd_on ? StRampUp : StOff;
          end else begin
            pause_cnt_d = pause_cnt_q + PauseW'(1);
          end
        end
        StFault: begin
          duty_d = '0;
          if (!cmd_on && ilock_ok) state_d = StOff;
        end
        default: begin
          state_d = StOff;
          duty_d  = '0;
        end
      endcase
    end

    brake_d   = (state_d == StPause) || (state_d == StFault);
    fault_d   = (state_d == StFault);
    running_d = (duty_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StOff;
      duty_q      <= '0;
      dir_cw_q    <= 1'b1;
      rev_q       <= 1'b0;
      brake_q     <= 1'b0;
      fault_q     <= 1'b0;
      running_q   <= 1'b0;
      div_cnt_q   <= '0;
      agit_cnt_q  <= '0;
      pause_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      duty_q      <= duty_d;
      dir_cw_q    <= dir_cw_d;
      rev_q       <= rev_d;
      brake_q     <= brake_d;
      fault_q     <= fault_d;
      running_q   <= running_d;
      div_cnt_q   <= div_cnt_d;
      agit_cnt_q  <= agit_cnt_d;
      pause_cnt_q <= pause_cnt_d;
    end
  end

  motor_drive_ctrl_pwm_gen #(
    .PwmBits(PWM_BITS)
  ) u_pwm_gen (
    .clk_i (clk),
    .rst_i (rst),
    .duty_i(duty_q),
    .pwm_o (pwm_out)
  );

  assign duty    = duty_q;
  assign dir_cw  = dir_cw_q;
  assign brake   = brake_q;
  assign fault   = fault_q;
  assign running = running_q;

endmodule

// File: tb/tb_motor_drive_ctrl.sv
// Directed bench for motor_drive_ctrl; a second instance with a 64 wash level checks PWM shape.
// Cycle counts below are edges after the last reset edge (E0) of the main instance.
module tb_motor_drive_ctrl;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, lock_door, door_closed;
  logic [1:0] motor_cmd;
  logic       pwm_out, dir_cw, brake, running, fault;
  logic [7:0] duty;

  logic       rst64;
  logic [1:0] cmd64;
  logic       pwm64, dir64, brake64, run64, fault64;
  logic [7:0] duty64;

  int checks   = 0;
  int errors   = 0;
  int dir_viol = 0;

  motor_drive_ctrl u_dut (
    .clk        (clk),
    .rst        (rst),
    .motor_cmd  (motor_cmd),
    .lock_door  (lock_door),
    .door_closed(door_closed),
    .pwm_out    (pwm_out),
    .dir_cw     (dir_cw),
    .brake      (brake),
    .running    (running),
    .fault      (fault),
    .duty       (duty)
  );

  motor_drive_ctrl #(
    .WASH_DUTY   (64),
    .AGITATE_TIME(1000)
  ) u_dut64 (
    .clk        (clk),
    .rst        (rst64),
    .motor_cmd  (cmd64),
    .lock_door  (1'b1),
    .door_closed(1'b1),
    .pwm_out    (pwm64),
    .dir_cw     (dir64),
    .brake      (brake64),
    .running    (run64),
    .fault      (fault64),
    .duty       (duty64)
  );

  // Direction must never move while duty is nonzero on either side of the change.
  logic       mon_en    = 1'b0;
  logic       prev_dir  = 1'b1;
  logic [7:0] prev_duty = 8'd0;
  always @(negedge clk) begin
    if (mon_en) begin
      if ((dir_cw !== prev_dir) && ((duty != 8'd0) || (prev_duty != 8'd0)))
        dir_viol <= dir_viol + 1;
      prev_dir  <= dir_cw;
      prev_duty <= duty;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_duty(input logic [7:0] tgt, input int budget, output int cycles);
    cycles = 0;
    do begin
      step(1);
      cycles++;
    end while ((duty !== tgt) && (cycles < budget));
  endtask

  task automatic count_pwm(input bit use64, output int c);
    c = 0;
    repeat (256) begin
      step(1);
      c += use64 ? int'(pwm64) : int'(pwm_out);
    end
  endtask

  task automatic count_brake(output int c);
    c = int'(brake);
    repeat (5) begin
      step(1);
      c += int'(brake);
    end
  endtask

  int cyc;
  int cnt;

  initial begin
    rst         = 1'b1;
    rst64       = 1'b1;
    motor_cmd   = 2'd0;
    cmd64       = 2'd0;
    lock_door   = 1'b1;
    door_closed = 1'b1;
    step(2);
    check("rst_duty", duty, 0);
    check("rst_dir", dir_cw, 1);
    check("rst_pwm", pwm_out, 0);
    check("rst_brake", brake, 0);
    check("rst_running", running, 0);
    check("rst_fault", fault, 0);
    mon_en = 1'b1;

    // PWM shape on the 64-level instance: idle is constant low, then 64 of 256 high.
    rst64 = 1'b0;
    count_pwm(1'b1, cnt);
    check("pwm_idle_zero", cnt, 0);
    cmd64 = 2'd1;
    cyc = 0;
    do begin
      step(1);
      cyc++;
    end while ((duty64 !== 8'd64) && (cyc < 200));
    check("ramp64_cycles", cyc, 64);
    count_pwm(1'b1, cnt);
    check("pwm_duty64", cnt, 64);

    // Wash ramp: tick edges are E4, E8, ...; 128 reached at E128.
    rst       = 1'b0;
    motor_cmd = 2'd1;
    step(3);
    check("ramp_e3_duty", duty, 0);
    step(1);
    check("ramp_e4_duty", duty, 4);
    check("ramp_running", running, 1);
    check("ramp_brake", brake, 0);
    wait_duty(8'd128, 300, cyc);
    check("wash_reach_cycles", cyc, 124);

    // Agitation: RUN E129..E144, ramp down to 0 at E272, pause, ramp back at E404.
    wait_duty(8'd0, 400, cyc);
    check("agit_down_cycles", cyc, 144);
    count_brake(cnt);
    check("agit_pause_brake", cnt, 4);
    check("agit_dir_ccw", dir_cw, 0);
    wait_duty(8'd128, 300, cyc);
    check("agit_up_cycles", cyc, 127);
    check("agit_dir_hold", dir_cw, 0);

    // Wash->spin from CCW: down to 0 at E532, pause, CW, 240 at E776.
    motor_cmd = 2'd2;
    wait_duty(8'd0, 400, cyc);
    check("spin_down_cycles", cyc, 128);
    count_brake(cnt);
    check("spin_pause_brake", cnt, 4);
    check("spin_dir_cw", dir_cw, 1);
    wait_duty(8'd240, 400, cyc);
    check("spin_up_cycles", cyc, 239);
    check("spin_running", running, 1);
    count_pwm(1'b0, cnt);
    check("pwm_duty240", cnt, 240);

    // cmd=3 behaves as off: plain ramp down from E1033, 0 at E1272, no brake.
    motor_cmd = 2'd3;
    wait_duty(8'd0, 400, cyc);
    check("cmd3_down_cycles", cyc, 240);
    check("cmd3_brake", brake, 0);
    check("cmd3_running", running, 0);

    // Door opens at duty 200 (E1472); sticky fault until cmd 0 with door shut and locked.
    motor_cmd = 2'd2;
    wait_duty(8'd200, 400, cyc);
    check("door_reach_cycles", cyc, 200);
    door_closed = 1'b0;
    step(1);
    check("flt_duty", duty, 0);
    check("flt_brake", brake, 1);
    check("flt_fault", fault, 1);
    check("flt_running", running, 0);
    door_closed = 1'b1;
    step(3);
    check("flt_sticky_cmd", fault, 1);
    check("flt_pwm", pwm_out, 0);
    motor_cmd = 2'd0;
    lock_door = 1'b0;
    step(2);
    check("flt_sticky_unlock", fault, 1);
    lock_door = 1'b1;
    step(1);
    check("flt_clear", fault, 0);
    check("flt_clear_brake", brake, 0);

    // Reset mid-spin: ramp from OFF at E1479, 40 at E1520, then reset values next edge.
    motor_cmd = 2'd2;
    wait_duty(8'd40, 200, cyc);
    check("rst_mid_cycles", cyc, 41);
    rst = 1'b1;
    step(1);
    check("rst_mid_duty", duty, 0);
    check("rst_mid_dir", dir_cw, 1);
    check("rst_mid_brake", brake, 0);
    check("rst_mid_running", running, 0);
    check("rst_mid_fault", fault, 0);
    step(1);
    check("rst_mid_pwm", pwm_out, 0);

    check("dir_change_at_zero", dir_viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
